// File: rtl/decoder_38_seq_pkg.sv
// Purpose : shared constants and state encoding for the 3-to-8 decoder sequencer.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package decoder_38_seq_pkg;

    localparam int NUM_CH = 8;
    localparam int CH_W   = 3;

    // ST_GAP is only entered when DECODER_38_SEQ_GAP_EN is defined.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

endpackage

// File: rtl/decoder_38_seq_if.sv
// Purpose : control/status bundle between a controller and the sequencer.
// Latency : n/a (wires only).
// Backpressure: none; start is honoured only while the sequencer is idle.
// Ports: start/stop/loop/mask/dwell from master; en/a/b/c/busy/done from slave.
interface decoder_38_seq_if #(
    parameter int DWELL_W = 8
);
    import decoder_38_seq_pkg::*;

    logic               start;
    logic               stop;
    logic               loop;
    logic [NUM_CH-1:0]  mask;
    logic [DWELL_W-1:0] dwell;
    logic               en;
    logic               a;
    logic               b;
    logic               c;
    logic               busy;
    logic               done;

    modport master (
        output start, stop, loop, mask, dwell,
        input  en, a, b, c, busy, done
    );

    modport slave (
        input  start, stop, loop, mask, dwell,
        output en, a, b, c, busy, done
    );

endinterface

// File: rtl/decoder_38_next_ch.sv
// Purpose : find the next enabled channel above cur_ch and the lowest enabled channel.
// Latency : combinational.
// Backpressure: n/a.
// Ports: mask, cur_ch in; next_ch, has_higher, lowest_ch out.
module decoder_38_next_ch
    import decoder_38_seq_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  logic [CH_W-1:0]   cur_ch,
    output logic [CH_W-1:0]   next_ch,
    output logic              has_higher,
    output logic [CH_W-1:0]   lowest_ch
);

    // Scan from the top down so the last hit wins: that leaves the lowest
    // set bit overall and the lowest set bit strictly above cur_ch.
    always_comb begin
        next_ch    = cur_ch;
        has_higher = 1'b0;
        lowest_ch  = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i]) begin
                lowest_ch = CH_W'(i);
                if (CH_W'(i) > cur_ch) begin
                    next_ch    = CH_W'(i);
                    has_higher = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/decoder_38_seq.sv
// Purpose : walk a latched channel mask in ascending order, holding each channel for dwell cycles.
// Latency : en/abc valid one cycle after an accepted start; done one cycle after the last dwell cycle or stop.
// Backpressure: start ignored while busy; stop aborts on the next edge.
// Ports: clk, rst (async, active-high); bus (slave modport: start/stop/loop/mask/dwell in, en/a/b/c/busy/done out).
// Build option: define DECODER_38_SEQ_GAP_EN for a one-cycle en=0 gap between channels.
module decoder_38_seq
    import decoder_38_seq_pkg::*;
#(
    parameter int DWELL_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    decoder_38_seq_if.slave  bus
);

    state_t             state_q, state_d;
    logic [NUM_CH-1:0]  mask_q, mask_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [CH_W-1:0]    ch_q, ch_d;
    logic               en_q, en_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [NUM_CH-1:0]  sel_mask;
    logic [CH_W-1:0]    next_ch;
    logic               has_higher;
    logic [CH_W-1:0]    lowest_ch;
    logic [DWELL_W-1:0] dwell_eff_in;

    // In IDLE the finder looks at the live mask so the first channel can be
    // loaded on the start edge; otherwise it works on the latched copy.
    assign sel_mask     = (state_q == ST_IDLE) ? bus.mask : mask_q;
    assign dwell_eff_in = (bus.dwell == '0) ? DWELL_W'(1) : bus.dwell;

    decoder_38_next_ch u_next_ch (
        .mask       (sel_mask),
        .cur_ch     (ch_q),
        .next_ch    (next_ch),
        .has_higher (has_higher),
        .lowest_ch  (lowest_ch)
    );

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        dwell_d = dwell_q;
        cnt_d   = cnt_q;
        ch_d    = ch_q;
        en_d    = en_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                en_d   = 1'b0;
                ch_d   = '0;
                busy_d = 1'b0;
                cnt_d  = '0;
                // stop is deliberately ignored here so start wins a tie.
                if (bus.start) begin
                    if (bus.mask != '0) begin
                        mask_d  = bus.mask;
                        dwell_d = dwell_eff_in;
                        ch_d    = lowest_ch;
                        cnt_d   = DWELL_W'(1);
                        en_d    = 1'b1;
                        busy_d  = 1'b1;
                        state_d = ST_DRIVE;
                    end else begin
                        done_d  = 1'b1;
                    end
                end
            end

            ST_DRIVE: begin
                if (bus.stop) begin
                    state_d = ST_IDLE;
                    en_d    = 1'b0;
                    ch_d    = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (cnt_q >= dwell_q) begin
                    if (has_higher || bus.loop) begin
                        ch_d = has_higher ? next_ch : lowest_ch;
`ifdef DECODER_38_SEQ_GAP_EN
                        // Break-before-make: select lines move while en is low.
                        state_d = ST_GAP;
                        en_d    = 1'b0;
                        cnt_d   = '0;
`else
                        en_d    = 1'b1;
                        cnt_d   = DWELL_W'(1);
`endif
                    end else begin
                        state_d = ST_IDLE;
                        en_d    = 1'b0;
                        ch_d    = '0;
                        cnt_d   = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + DWELL_W'(1);
                end
            end

`ifdef DECODER_38_SEQ_GAP_EN
            ST_GAP: begin
                if (bus.stop) begin
                    state_d = ST_IDLE;
                    en_d    = 1'b0;
                    ch_d    = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_DRIVE;
                    en_d    = 1'b1;
                    cnt_d   = DWELL_W'(1);
                end
            end
`endif

            default: begin
                state_d = ST_IDLE;
                en_d    = 1'b0;
                ch_d    = '0;
                cnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mask_q  <= '0;
            dwell_q <= '0;
            cnt_q   <= '0;
            ch_q    <= '0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            dwell_q <= dwell_d;
            cnt_q   <= cnt_d;
            ch_q    <= ch_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Channel n drives {a,b,c} = n with a as the MSB.
    assign bus.en   = en_q;
    assign bus.a    = ch_q[2];
    assign bus.b    = ch_q[1];
    assign bus.c    = ch_q[0];
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule
